// File: rtl/nco_multichannel_if.sv
// Control/config bus and sample outputs of the multichannel NCO.
// Master drives controls and config, slave returns samples.
interface nco_multichannel_if #(
  parameter int N_CH    = 4,
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 16
);
  logic                    enable;
  logic                    sync_reset;
  logic                    cfg_we;
  logic [3:0]              cfg_ch;
  logic                    cfg_sel;
  logic [PHASE_W-1:0]      cfg_data;
  logic                    commit;
  logic                    dither_en;
  logic [N_CH*OUT_W-1:0]   sin_out;
  logic [N_CH*OUT_W-1:0]   cos_out;
  logic                    valid_out;

  modport master (
    output enable, sync_reset, cfg_we, cfg_ch,
    output cfg_sel, cfg_data, commit, dither_en,
    input  sin_out, cos_out, valid_out
  );

  modport slave (
    input  enable, sync_reset, cfg_we, cfg_ch,
    input  cfg_sel, cfg_data, commit, dither_en,
    output sin_out, cos_out, valid_out
  );
endinterface

// File: rtl/nco_multichannel.sv
// Multichannel NCO: double-buffered tuning, quarter-wave LUT,
// optional LFSR phase dither, 3-stage pipeline with valid flag.
module nco_multichannel #(
  parameter int N_CH     = 4,
  parameter int PHASE_W  = 32,
  parameter int LUT_AW   = 8,
  parameter int OUT_W    = 16,
  parameter int DITHER_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  nco_multichannel_if.slave   bus
);
  localparam int N  = 1 << LUT_AW;
  localparam int SH = PHASE_W - 2 - LUT_AW;
  localparam logic [31:0] SEED = 32'hACE10001;
  localparam logic [31:0] TAPS = 32'h80200003;

  // Half-sample-offset sine, Taylor series evaluated at elaboration.
  function automatic logic [OUT_W-1:0] lut_val(input int k);
    real x, x2, term, s, amp;
    int  v;
    x    = (real'(k) + 0.5) * 3.14159265358979323846
           / (2.0 * real'(N));
    x2   = x * x;
    term = x;
    s    = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x2 / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    amp = real'((longint'(1) << (OUT_W - 1)) - 1);
    v   = $rtoi(s * amp + 0.5);
    return v[OUT_W-1:0];
  endfunction

  logic [OUT_W-1:0] lut [N];

  for (genvar k = 0; k < N; k++) begin : g_lut
    localparam logic [OUT_W-1:0] TV = lut_val(k);
    assign lut[k] = TV;
  end

  logic [31:0] lfsr_q, lfsr_d;
  logic        v1_q, v2_q, v3_q;

  assign lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 32'h0);
  assign bus.valid_out = v3_q;

  // Shared dither LFSR and per-stage valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
    end else if (bus.sync_reset) begin
      lfsr_q <= SEED;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
    end else begin
      if (bus.enable) lfsr_q <= lfsr_d;
      v1_q <= bus.enable;
      v2_q <= bus.enable & v1_q;
      v3_q <= bus.enable & v2_q;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [PHASE_W-1:0] sfreq_q, soff_q;
    logic [PHASE_W-1:0] afreq_q, aoff_q, acc_q;
    logic [PHASE_W-1:0] sfreq_d, soff_d, p_d;
    logic [DITHER_W-1:0] dith;
    logic [1:0]          q1_q, q2_q;
    logic [LUT_AW-1:0]   i1_q;
    logic [OUT_W-1:0]    ta_q, tb_q, sin_q, cos_q;
    logic                hit, unused_lsb;

    assign hit     = bus.cfg_we && (int'(bus.cfg_ch) == c);
    assign sfreq_d = (hit && !bus.cfg_sel) ? bus.cfg_data : sfreq_q;
    assign soff_d  = (hit && bus.cfg_sel) ? bus.cfg_data : soff_q;

    for (genvar b = 0; b < DITHER_W; b++) begin : g_dith
      assign dith[b] = lfsr_q[(b + c) % 32];
    end

    assign p_d = acc_q + aoff_q
               + (bus.dither_en
                  ? {{(PHASE_W-DITHER_W){1'b0}}, dith}
                  : {PHASE_W{1'b0}});
    assign unused_lsb = ^p_d[SH-1:0];

    assign bus.sin_out[c*OUT_W +: OUT_W] = sin_q;
    assign bus.cos_out[c*OUT_W +: OUT_W] = cos_q;

    // Shadow/active tuning registers and phase accumulator.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sfreq_q <= '0;
        soff_q  <= '0;
        afreq_q <= '0;
        aoff_q  <= '0;
        acc_q   <= '0;
      end else if (bus.sync_reset) begin
        acc_q <= '0;
      end else begin
        sfreq_q <= sfreq_d;
        soff_q  <= soff_d;
        if (bus.commit) begin
          afreq_q <= sfreq_d;
          aoff_q  <= soff_d;
        end
        if (bus.enable) acc_q <= acc_q + afreq_q;
      end
    end

    // Phase -> LUT fetch -> quadrant fold, advancing on enable.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q1_q  <= '0;
        i1_q  <= '0;
        q2_q  <= '0;
        ta_q  <= '0;
        tb_q  <= '0;
        sin_q <= '0;
        cos_q <= '0;
      end else if (bus.enable && !bus.sync_reset) begin
        q1_q <= p_d[PHASE_W-1 -: 2];
        i1_q <= p_d[PHASE_W-3 -: LUT_AW];
        q2_q <= q1_q;
        ta_q <= lut[i1_q];
        tb_q <= lut[~i1_q];
        unique case (q2_q)
          2'd0: begin sin_q <= ta_q;  cos_q <= tb_q;  end
          2'd1: begin sin_q <= tb_q;  cos_q <= -ta_q; end
          2'd2: begin sin_q <= -ta_q; cos_q <= -tb_q; end
          2'd3: begin sin_q <= -tb_q; cos_q <= ta_q;  end
        endcase
      end
    end
  end
endmodule

// File: doc/nco_multichannel.md
Name: nco_multichannel

Overview:
- Parametrised multi-channel NCO for the digital downconverter; produces N_CH independent sine/cosine pairs in parallel, one sample per channel per enabled clock.
- Per-channel frequency word and phase offset are double-buffered: written through a config port, then applied to all channels at once on commit.
- Quarter-wave LUT with exact half-sample symmetry, optional LFSR phase dither, and a 3-cycle pipeline with a valid flag.
- Sits between the control register bank and the complex mixers.

Parameters:
N_CH, 4, number of channels (1..16)
PHASE_W, 32, phase accumulator width
LUT_AW, 8, quarter-wave table address bits (table depth 2^LUT_AW)
OUT_W, 16, signed output sample width
DITHER_W, 8, dither bits added to phase LSBs; must be <= PHASE_W-2-LUT_AW

Ports:
clk  in  1  processing clock; the only clock
rst  in  1  asynchronous reset, active-high
enable  in  1  advance accumulators and pipeline
sync_reset  in  1  synchronous clear of all accumulators and the pipeline valids
cfg_we  in  1  write strobe to the shadow registers
cfg_ch  in  4  target channel index
cfg_sel  in  1  0 = frequency word, 1 = phase offset
cfg_data  in  PHASE_W  write data
commit  in  1  copy all shadow registers to active registers
dither_en  in  1  add LFSR dither to the phase
sin_out  out  N_CH*OUT_W  signed sine, channel c at bits [c*OUT_W +: OUT_W]
cos_out  out  N_CH*OUT_W  signed cosine, same packing
valid_out  out  1  sin_out/cos_out valid this cycle

Behaviour:
- Reset (rst=1, async): all accumulators, shadow and active registers = 0; pipeline registers = 0; sin_out = cos_out = 0; valid_out = 0; LFSR = 32'hACE10001.
- Config writes:
  - cfg_we writes cfg_data to shadow_freq[cfg_ch] or shadow_off[cfg_ch], selected by cfg_sel.
  - cfg_ch >= N_CH: write ignored.
- Commit:
  - On commit, every active register takes its shadow value at the next edge.
  - If cfg_we and commit are asserted in the same cycle, the written value goes into both its shadow and its active register.
  - Commit takes effect regardless of enable.
- Accumulator, per channel, when enable=1: acc <= acc + active_freq (mod 2^PHASE_W). When enable=0, acc holds.
- Stage 1 (registered): p = acc + active_off + (dither_en ? zero-extended lfsr[DITHER_W-1:0] : 0), mod 2^PHASE_W, using pre-update acc.
- LFSR:
  - 32-bit Galois, taps mask 32'h80200003, shift right.
  - Advances only when enable=1.
  - One shared LFSR for all channels; channel c uses the LFSR value rotated right by c bits.
- Stage 2 (registered): q = p[PHASE_W-1 -: 2], i = p[PHASE_W-3 -: LUT_AW], N = 2^LUT_AW. Fetch T[i] and T[N-1-i].
- LUT: T[k] = round(sin((k+0.5)*pi/(2N)) * (2^(OUT_W-1)-1)), precomputed at elaboration.
- Stage 3 (registered outputs), by quadrant q:
  - q0: sin = T[i], cos = T[N-1-i]
  - q1: sin = T[N-1-i], cos = -T[i]
  - q2: sin = -T[i], cos = -T[N-1-i]
  - q3: sin = -T[N-1-i], cos = T[i]
  - Negation is two's complement; no result reaches -2^(OUT_W-1).
- Pipeline control:
  - The pipeline advances only when enable=1; with enable=0 all stages and outputs hold.
  - valid_out = enable delayed by 3 cycles through per-stage valid bits.
  - A stage's valid bit clears when that stage holds on enable=0.
  - Latency: a phase present in acc on an enabled edge appears on the outputs 3 enabled edges later.
- sync_reset:
  - Takes priority over enable and commit.
  - At the next edge: all acc = 0, all stage valid bits = 0, LFSR reseeded to 32'hACE10001.
  - Data registers, shadow and active registers are unchanged.
- Wrap-around: accumulator overflow is silent modulo arithmetic; no flag.
- Reset mid-operation: outputs and valid_out go to 0 immediately (async).

Test Plan:
- Defaults, ch0 freq = 32'h40000000, commit, enable held, dither off -> after 3 cycles ch0 (sin,cos) repeats (101,32767), (32767,-101), (-101,-32767), (-32767,101); valid_out rises exactly 3 cycles after enable.
- Write ch1 offset = 32'h80000000 without commit -> ch1 output unchanged; after commit (freq 0) ch1 = (-101,-32767) after 3 enabled cycles, while ch0 keeps (101,32767).
- cfg_we ch2 freq = 32'h40000000 with commit in the same cycle -> ch2 active updated at that edge; ch2 quadrant sequence starts with no extra cycle of delay.
- Toggle enable 1,0,0,1 -> outputs and acc hold during the 0 cycles; valid_out deasserts at the matching delayed points; no sample skipped or repeated.
- sync_reset while running with ch0 freq = 32'h12345678 -> valid_out low for 3 cycles; the first valid sample equals phase 0 + offset; two runs with dither_en=1 give bit-identical outputs.
- cfg_ch = 9 write with N_CH=4 -> no register changes; async rst asserted mid-stream -> sin_out = cos_out = 0 and valid_out = 0 immediately.
